// File: rtl/dl_rom_region.sv
// rtl/dl_rom_region.sv - download-loaded ROM region with load verification and gated CPU reads
module dl_rom_region #(
    parameter int          AW   = 15,
    parameter int          DW   = 8,
    parameter logic [26:0] BASE = 27'h21000,
    parameter int          SIZE = 32768,
    parameter logic [7:0]  FILL = 8'hFF
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic [AW-1:0] cpu_ab,
    input  logic          cpu_rd,
    output logic [DW-1:0] cpu_data,
    input  logic          ioctl_download,
    input  logic [26:0]   ioctl_addr,
    input  logic [15:0]   ioctl_dout,
    input  logic          ioctl_wr,
    output logic          loaded,
    output logic          load_err,
    output logic [7:0]    checksum,
    output logic [AW:0]   wr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADING,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    // Window bounds carry one extra bit so BASE+SIZE cannot wrap the 27-bit address space.
    localparam logic [27:0]   BASE_X  = {1'b0, BASE};
    localparam logic [27:0]   END_X   = BASE_X + 28'(SIZE);
    localparam logic [AW:0]   SIZE_C  = (AW+1)'(SIZE);
    localparam logic [AW:0]   CNT_MAX = '1;
    localparam logic [DW-1:0] FILL_C  = DW'(FILL);

    state_t          state_q, state_d;
    logic            dl_q, dl_d;
    logic            armed_q, armed_d;
    logic            wr_pend_q, wr_pend_d;
    logic [AW-1:0]   wr_idx_q, wr_idx_d;
    logic [15:0]     wr_data_q, wr_data_d;
    logic [AW:0]     wr_count_q, wr_count_d;
    logic [7:0]      checksum_q, checksum_d;
    logic [DW-1:0]   cpu_data_q, cpu_data_d;

    logic [DW-1:0]   mem [0:(1<<AW)-1];

    logic [27:0]     addr_x;
    logic            in_win;
    logic            dl_rise;
    logic            dl_fall;
    logic            load_start;
    logic            unused_bits;

    // Only part of the registered download word may reach the RAM, depending on DW.
    assign unused_bits = ^wr_data_q;

    // Download window decode, edge detection and the write capture stage.
    always_comb begin
        addr_x     = {1'b0, ioctl_addr};
        in_win     = (addr_x >= BASE_X) && (addr_x < END_X);
        // armed_q stays low until download has been seen low, so a download already
        // active at reset release does not count as a rising edge.
        armed_d    = armed_q | ~ioctl_download;
        dl_d       = ioctl_download;
        dl_rise    = ioctl_download & ~dl_q & armed_q;
        dl_fall    = ~ioctl_download & dl_q;
        load_start = dl_rise && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
        wr_pend_d  = ioctl_download & ioctl_wr & in_win;
        wr_idx_d   = AW'(ioctl_addr - BASE);
        wr_data_d  = ioctl_dout;
    end

    // Load state machine: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (load_start) state_d = S_LOADING;
            S_LOADING: if (dl_fall) state_d = S_CHECK;
            // One cycle here lets a write captured in the final download cycle land in wr_count.
            S_CHECK:   state_d = (wr_count_q == SIZE_C) ? S_DONE : S_ERROR;
            S_DONE:    if (load_start) state_d = S_LOADING;
            S_ERROR:   if (load_start) state_d = S_LOADING;
            default:   state_d = S_IDLE;
        endcase
    end

    // Write counter and checksum: cleared at load start, advanced one cycle after capture.
    always_comb begin
        wr_count_d = wr_count_q;
        checksum_d = checksum_q;
        if (load_start) begin
            wr_count_d = '0;
            checksum_d = 8'h00;
        end else if (wr_pend_q) begin
            if (wr_count_q != CNT_MAX) wr_count_d = wr_count_q + 1'b1;
            checksum_d = checksum_q + wr_data_q[7:0];
        end
    end

    // CPU read port: only a verified region is visible, everything else reads as FILL.
    always_comb begin
        cpu_data_d = cpu_data_q;
        if (cpu_rd) begin
            if (state_q == S_DONE && {1'b0, cpu_ab} < SIZE_C) cpu_data_d = mem[cpu_ab];
            else                                              cpu_data_d = FILL_C;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            dl_q       <= 1'b0;
            armed_q    <= 1'b0;
            wr_pend_q  <= 1'b0;
            wr_idx_q   <= '0;
            wr_data_q  <= '0;
            wr_count_q <= '0;
            checksum_q <= 8'h00;
            cpu_data_q <= '0;
        end else begin
            state_q    <= state_d;
            dl_q       <= dl_d;
            armed_q    <= armed_d;
            wr_pend_q  <= wr_pend_d;
            wr_idx_q   <= wr_idx_d;
            wr_data_q  <= wr_data_d;
            wr_count_q <= wr_count_d;
            checksum_q <= checksum_d;
            cpu_data_q <= cpu_data_d;
        end
    end

    // Region storage; contents deliberately survive reset.
    always_ff @(posedge clk_sys) begin
        if (wr_pend_q) mem[wr_idx_q] <= wr_data_q[DW-1:0];
    end

    assign cpu_data = cpu_data_q;
    assign loaded   = (state_q == S_DONE);
    assign load_err = (state_q == S_ERROR);
    assign checksum = checksum_q;
    assign wr_count = wr_count_q;

endmodule
